// File: rtl/bcd_to_operand_pkg.sv
// Shared types and constants for the BCD entry-to-operand converter.
package bcd_to_operand_pkg;

  localparam int DEF_OUTPUTWIDTH = 32;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_INT    = 3'd2,
    ST_FRAC   = 3'd3,
    ST_FINISH = 3'd4
  } state_t;

  // Sign nibble codes shared with the result-to-BCD display path.
  localparam logic [3:0] BCD_SIGN_POS = 4'h0;
  localparam logic [3:0] BCD_SIGN_NEG = 4'hF;

  localparam int INT_DIGITS  = 7;
  localparam int FRAC_DIGITS = 7;
  localparam int INT_W       = 4 * INT_DIGITS;
  localparam int FRAC_W      = 4 * FRAC_DIGITS;

  function automatic logic bcd_has_bad_digit(input logic [INT_W-1:0] digits);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < INT_DIGITS; i++) begin
      bad = bad | (digits[4*i +: 4] > 4'd9);
    end
    return bad;
  endfunction

endpackage

// File: rtl/bcd_to_operand_frac_double.sv
// One combinational doubling step of a 7-digit BCD fraction; the carry out
// of the most significant digit is the next binary fraction bit.
module bcd_frac_double
  import bcd_to_operand_pkg::*;
(
  input  logic [FRAC_W-1:0] i_frac,
  output logic [FRAC_W-1:0] o_frac,
  output logic              o_carry
);

  logic [FRAC_W-1:0] w_adj;

  // Pre-correct each digit so the following 1-bit shift doubles it in BCD.
  always_comb begin
    w_adj = {FRAC_W{1'b0}};
    for (int i = 0; i < FRAC_DIGITS; i++) begin
      if (i_frac[4*i +: 4] >= 4'd5) begin
        w_adj[4*i +: 4] = i_frac[4*i +: 4] + 4'd3;
      end else begin
        w_adj[4*i +: 4] = i_frac[4*i +: 4];
      end
    end
  end

  assign {o_carry, o_frac} = {w_adj, 1'b0};

endmodule

// File: rtl/bcd_to_operand.sv
// Iterative signed-BCD to two's-complement operand converter (integer or fixed-point).
// BCD_FRAC_ROUND_EN: adds one extra fraction cycle and rounds half-up instead of truncating.
module bcd_to_operand
  import bcd_to_operand_pkg::*;
#(
  parameter int M         = DEF_OUTPUTWIDTH,
  parameter int I_FRAC    = 8,
  parameter int BCD_WIDTH = 60
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic [BCD_WIDTH-1:0] i_bcd,
  input  logic                 i_fixed,
  input  logic                 i_ce,
  output logic [M-1:0]         o_val,
  output logic                 o_ovf,
  output logic                 o_err,
  output logic                 busy,
  output logic                 done
);

  localparam int ACC_W = M + 4;
`ifdef BCD_FRAC_ROUND_EN
  localparam int FB_W = I_FRAC + 1;
`else
  localparam int FB_W = I_FRAC;
`endif
  localparam int MAG_W = ACC_W + I_FRAC + 1;
  localparam int CNT_W = $clog2(FB_W + INT_DIGITS + 1);

  localparam logic [M-1:0]     MAX_POS   = {1'b0, {(M-1){1'b1}}};
  localparam logic [M-1:0]     MAX_NEG   = {1'b1, {(M-2){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] INT_LAST  = CNT_W'(INT_DIGITS - 1);
  localparam logic [CNT_W-1:0] FRAC_LAST = CNT_W'(FB_W - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t              r_state;
  logic [3:0]          r_sign;
  logic [INT_W-1:0]    r_int;
  logic [FRAC_W-1:0]   r_frac;
  logic                r_fixed;
  logic                r_neg;
  logic                r_err;
  logic [ACC_W-1:0]    r_acc;
  logic [FB_W-1:0]     r_fb;
  logic [CNT_W-1:0]    r_cnt;

  logic [FRAC_W-1:0]   w_frac_next;
  logic                w_frac_carry;
  logic [ACC_W-1:0]    w_acc_next;
  logic                w_rnd;
  logic [MAG_W-1:0]    w_mag;
  logic                w_ovf;
  logic [M-1:0]        w_res;
  logic                w_sign_bad;

  bcd_frac_double u_frac_double (
    .i_frac  (r_frac),
    .o_frac  (w_frac_next),
    .o_carry (w_frac_carry)
  );

  // acc*10 + next digit, with *10 built from two shifts.
  assign w_acc_next = (r_acc << 3) + (r_acc << 1)
                    + {{(ACC_W-4){1'b0}}, r_int[INT_W-1 -: 4]};

  assign w_sign_bad = (r_sign != BCD_SIGN_POS) && (r_sign != BCD_SIGN_NEG);

  // Round bit: the extra fraction carry, only meaningful in fixed mode.
  always_comb begin
`ifdef BCD_FRAC_ROUND_EN
    w_rnd = r_fixed & r_fb[0];
`else
    w_rnd = 1'b0;
`endif
  end

  // Magnitude assembly, symmetric saturation check and sign application.
  always_comb begin
    if (r_fixed) begin
      w_mag = {1'b0, r_acc, r_fb[FB_W-1 -: I_FRAC]};
    end else begin
      w_mag = {{(I_FRAC+1){1'b0}}, r_acc};
    end
    w_mag = w_mag + {{(MAG_W-1){1'b0}}, w_rnd};
    w_ovf = (w_mag > {{(MAG_W-M){1'b0}}, MAX_POS});
    if (r_neg) begin
      w_res = {M{1'b0}} - w_mag[M-1:0];
    end else begin
      w_res = w_mag[M-1:0];
    end
  end

  // Conversion FSM with registered outputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= ST_IDLE;
      r_sign  <= 4'h0;
      r_int   <= {INT_W{1'b0}};
      r_frac  <= {FRAC_W{1'b0}};
      r_fixed <= 1'b0;
      r_neg   <= 1'b0;
      r_err   <= 1'b0;
      r_acc   <= {ACC_W{1'b0}};
      r_fb    <= {FB_W{1'b0}};
      r_cnt   <= {CNT_W{1'b0}};
      o_val   <= {M{1'b0}};
      o_ovf   <= 1'b0;
      o_err   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          done <= 1'b0;
          if (i_ce) begin
            r_sign  <= i_bcd[INT_W+FRAC_W +: 4];
            r_int   <= i_bcd[FRAC_W +: INT_W];
            r_frac  <= i_bcd[FRAC_W-1:0];
            r_fixed <= i_fixed;
            busy    <= 1'b1;
            r_state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          // Fraction digits only matter, and are only checked, in fixed mode.
          r_err   <= w_sign_bad | bcd_has_bad_digit(r_int)
                   | (r_fixed & bcd_has_bad_digit(r_frac));
          r_neg   <= (r_sign == BCD_SIGN_NEG);
          r_acc   <= {ACC_W{1'b0}};
          r_fb    <= {FB_W{1'b0}};
          r_cnt   <= {CNT_W{1'b0}};
          r_state <= ST_INT;
        end
        ST_INT: begin
          r_acc <= w_acc_next;
          r_int <= {r_int[INT_W-5:0], 4'h0};
          if (r_cnt == INT_LAST) begin
            r_cnt   <= {CNT_W{1'b0}};
            r_state <= r_fixed ? ST_FRAC : ST_FINISH;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        ST_FRAC: begin
          r_frac <= w_frac_next;
          r_fb   <= {r_fb[FB_W-2:0], w_frac_carry};
          if (r_cnt == FRAC_LAST) begin
            r_cnt   <= {CNT_W{1'b0}};
            r_state <= ST_FINISH;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        ST_FINISH: begin
          if (r_err) begin
            o_val <= {M{1'b0}};
            o_err <= 1'b1;
            o_ovf <= 1'b0;
          end else if (w_ovf) begin
            o_val <= r_neg ? MAX_NEG : MAX_POS;
            o_err <= 1'b0;
            o_ovf <= 1'b1;
          end else begin
            o_val <= w_res;
            o_err <= 1'b0;
            o_ovf <= 1'b0;
          end
          done    <= 1'b1;
          busy    <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_to_operand.sv
// Scoreboard bench for bcd_to_operand (M=32, I_FRAC=8): directed vectors with
// hand-computed results; a monitor checks every done pulse against the queue.
module tb_bcd_to_operand;

`ifdef BCD_FRAC_ROUND_EN
  localparam int          FIX_LAT   = 18;
  localparam logic [31:0] EXP_TENTH = 32'h0000001A;
  localparam logic        EXP_NM_OVF = 1'b1;
`else
  localparam int          FIX_LAT   = 17;
  localparam logic [31:0] EXP_TENTH = 32'h00000019;
  localparam logic        EXP_NM_OVF = 1'b0;
`endif
  localparam int INT_LAT = 9;

  typedef struct {
    logic [59:0] bcd;
    logic        fixed;
    logic [31:0] val;
    logic        ovf;
    logic        err;
  } vec_t;

  typedef struct {
    logic [31:0] val;
    logic        ovf;
    logic        err;
    int          issue;
    int          lat;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic [59:0] i_bcd = 60'h0;
  logic        i_fixed = 1'b0;
  logic        i_ce = 1'b0;
  logic [31:0] o_val;
  logic        o_ovf, o_err, busy, done;

  exp_t sb[$];
  vec_t vecs[$];
  exp_t mon_e;
  int   n_chk = 0;
  int   n_pass = 0;
  int   cyc = 0;
  int   done_cnt = 0;

  bcd_to_operand #(.M(32), .I_FRAC(8), .BCD_WIDTH(60)) dut (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .i_bcd   (i_bcd),
    .i_fixed (i_fixed),
    .i_ce    (i_ce),
    .o_val   (o_val),
    .o_ovf   (o_ovf),
    .o_err   (o_err),
    .busy    (busy),
    .done    (done)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic add(input logic [59:0] bcd, input logic fixed, input logic [31:0] val,
                     input logic ovf, input logic err);
    vec_t v;
    v.bcd = bcd; v.fixed = fixed; v.val = val; v.ovf = ovf; v.err = err;
    vecs.push_back(v);
  endtask

  task automatic push_exp(input logic [31:0] val, input logic ovf, input logic err,
                          input int issue, input int lat);
    exp_t e;
    e.val = val; e.ovf = ovf; e.err = err; e.issue = issue; e.lat = lat;
    sb.push_back(e);
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge CLK) begin
    if (RST_N && done) begin
      done_cnt++;
      chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        chk("o_val", 64'(o_val), 64'(mon_e.val));
        chk("o_ovf", 64'(o_ovf), 64'(mon_e.ovf));
        chk("o_err", 64'(o_err), 64'(mon_e.err));
        chk("latency", 64'(cyc - mon_e.issue - 1), 64'(mon_e.lat));
        chk("busy_at_done", 64'(busy), 64'd0);
      end
    end
  end

  task automatic run_vec(input vec_t v);
    int  t;
    logic busy_ok;
    @(negedge CLK);
    i_bcd = v.bcd; i_fixed = v.fixed; i_ce = 1'b1;
    push_exp(v.val, v.ovf, v.err, cyc, v.fixed ? FIX_LAT : INT_LAT);
    @(negedge CLK);
    i_ce = 1'b0;
    i_bcd = ~v.bcd;
    i_fixed = ~v.fixed;
    busy_ok = 1'b1;
    t = 0;
    while (!done && t < 40) begin
      busy_ok = busy_ok & busy;
      t++;
      @(negedge CLK);
    end
    chk("done_seen", 64'(done), 64'd1);
    chk("busy_during", 64'(busy_ok), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int c;
    int d0;
    int t;

    add({4'h0, 28'h0000123, 28'h0000000}, 1'b0, 32'h0000007B, 1'b0, 1'b0);
    add({4'hF, 28'h0000003, 28'h5000000}, 1'b1, 32'hFFFFFC80, 1'b0, 1'b0);
    add({4'h0, 28'h0000000, 28'h1000000}, 1'b1, EXP_TENTH,    1'b0, 1'b0);
    add({4'h0, 28'h9999999, 28'h0000000}, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b0);
    add({4'hF, 28'h9999999, 28'h0000000}, 1'b1, 32'h80000001, 1'b1, 1'b0);
    add({4'h0, 28'h00000A0, 28'h0000000}, 1'b0, 32'h00000000, 1'b0, 1'b1);
    add({4'h5, 28'h0000001, 28'h0000000}, 1'b0, 32'h00000000, 1'b0, 1'b1);
    add({4'h0, 28'h0000042, 28'hFFFFFFF}, 1'b0, 32'h0000002A, 1'b0, 1'b0);
    add({4'h0, 28'h0000001, 28'h00B0000}, 1'b1, 32'h00000000, 1'b0, 1'b1);
    add({4'hF, 28'h1234567, 28'h0000000}, 1'b0, 32'hFFED2979, 1'b0, 1'b0);
    add({4'hF, 28'h0000000, 28'h0000000}, 1'b0, 32'h00000000, 1'b0, 1'b0);
    add({4'h0, 28'h9999999, 28'h0000000}, 1'b0, 32'h0098967F, 1'b0, 1'b0);
    add({4'h0, 28'h8388607, 28'h0000000}, 1'b1, 32'h7FFFFF00, 1'b0, 1'b0);
    add({4'h0, 28'h8388608, 28'h0000000}, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b0);
    add({4'h0, 28'h8388607, 28'h9999999}, 1'b1, 32'h7FFFFFFF, EXP_NM_OVF, 1'b0);
    add({4'hF, 28'h8388607, 28'h9999999}, 1'b1, 32'h80000001, EXP_NM_OVF, 1'b0);

    repeat (3) @(negedge CLK);
    chk("rst_val",  64'(o_val), 64'd0);
    chk("rst_busy", 64'(busy),  64'd0);
    chk("rst_done", 64'(done),  64'd0);
    chk("rst_flags", 64'({o_ovf, o_err}), 64'd0);
    RST_N = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // i_ce held high: second conversion starts the cycle after done.
    @(negedge CLK);
    d0 = done_cnt;
    i_bcd = {4'h0, 28'h0000123, 28'h0000000}; i_fixed = 1'b0; i_ce = 1'b1;
    c = cyc;
    push_exp(32'h0000007B, 1'b0, 1'b0, c, INT_LAT);
    push_exp(32'h0000007B, 1'b0, 1'b0, c + 10, INT_LAT);
    repeat (11) @(posedge CLK);
    @(negedge CLK);
    i_ce = 1'b0;
    t = 0;
    while (done_cnt - d0 < 2 && t < 40) begin t++; @(negedge CLK); end
    chk("b2b_done_count", 64'(done_cnt - d0), 64'd2);

    // i_ce pulses while busy must be ignored.
    @(negedge CLK);
    d0 = done_cnt;
    i_bcd = {4'h0, 28'h0000099, 28'h0000000}; i_fixed = 1'b0; i_ce = 1'b1;
    push_exp(32'h00000063, 1'b0, 1'b0, cyc, INT_LAT);
    @(negedge CLK); i_ce = 1'b0;
    repeat (2) @(negedge CLK); i_ce = 1'b1;
    @(negedge CLK); i_ce = 1'b0;
    repeat (2) @(negedge CLK); i_ce = 1'b1;
    @(negedge CLK); i_ce = 1'b0;
    repeat (30) @(negedge CLK);
    chk("busy_ce_one_done", 64'(done_cnt - d0), 64'd1);

    // Reset in the middle of the integer phase aborts with no done.
    @(negedge CLK);
    i_bcd = {4'h0, 28'h0000777, 28'h0000000}; i_fixed = 1'b0; i_ce = 1'b1;
    @(negedge CLK); i_ce = 1'b0;
    repeat (5) @(posedge CLK);
    @(negedge CLK);
    d0 = done_cnt;
    RST_N = 1'b0;
    #1;
    chk("abort_val",  64'(o_val), 64'd0);
    chk("abort_busy", 64'(busy),  64'd0);
    chk("abort_done", 64'(done),  64'd0);
    chk("abort_flags", 64'({o_ovf, o_err}), 64'd0);
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    repeat (25) @(negedge CLK);
    chk("abort_no_done", 64'(done_cnt - d0), 64'd0);

    begin
      vec_t v;
      v.bcd = {4'hF, 28'h0000777, 28'h2500000}; v.fixed = 1'b1;
      v.val = 32'hFFFCF6C0; v.ovf = 1'b0; v.err = 1'b0;
      run_vec(v);
    end

    repeat (5) @(negedge CLK);
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/bcd_to_operand.md
Name: bcd_to_operand

Overview:
- Converts a signed BCD entry word from the keypad/entry path into an M-bit two's-complement operand for the ALU. It is the inverse of the result-to-BCD display path.
- Input layout: 1 sign nibble, 7 integer digits, 7 fractional digits, MSD first.
- Output: either a plain integer, or fixed-point with I_FRAC fraction bits.
- Iterative engine, one digit or one fraction bit per clock.

Parameters:
M, `OUTPUTWIDTH (32), operand width in bits.
I_FRAC, 8, fraction bits when i_fixed=1.
BCD_WIDTH, 60, entry width: 15 nibbles = sign + 7 integer + 7 fraction.

Ports:
CLK  input  1  clock, rising edge.
RST_N  input  1  reset, asynchronous, active-low.
i_bcd  input  BCD_WIDTH  entry word. [59:56] sign, [55:28] integer digits, [27:0] fraction digits.
i_fixed  input  1  1 = fixed-point result, 0 = integer result (fraction digits ignored).
i_ce  input  1  start strobe; sampled only in IDLE.
o_val  output  M  converted operand; holds its value until the next FINISH.
o_ovf  output  1  magnitude saturated; valid with done.
o_err  output  1  illegal sign nibble or digit > 9; valid with done.
busy  output  1  high in every state except IDLE.
done  output  1  single-cycle completion pulse.

Behaviour:
- Reset (RST_N low, asynchronous): state=IDLE; o_val=0, o_ovf=0, o_err=0, busy=0, done=0; all internal accumulators 0. Reset mid-conversion aborts it with no done pulse.
- IDLE: done<=0. If i_ce=1, latch i_bcd and i_fixed, then go to LOAD. i_ce in any other state is ignored.
- LOAD:
  - Check the sign nibble: 4'h0 = positive, 4'hF = negative, anything else sets the internal error flag.
  - Check every nibble used by this conversion; any nibble > 9 sets the error flag. Fraction nibbles are checked only when i_fixed=1.
  - Clear the integer accumulator acc, clear the fraction register fb, clear the digit counter. Go to INT.
- INT: exactly 7 cycles, MSD first.
  - acc <= acc*10 + digit; implement *10 as (acc<<3)+(acc<<1).
  - acc is M+4 bits wide, so it never wraps.
  - After the 7th cycle: go to FRAC if i_fixed=1, else go to FINISH.
- FRAC: exactly I_FRAC cycles.
  - Double the 7-digit BCD fraction: each digit +3 if >=5, then shift left 1 bit across digits.
  - The carry out of the MSD becomes the next fraction bit, shifted into fb from the LSB side (first carry = MSB of fb).
  - Then go to FINISH.
- FINISH: 1 cycle.
  - mag = i_fixed ? {acc, fb} : acc.
  - If the error flag is set: o_val<=0, o_err<=1, o_ovf<=0.
  - Else if mag > 2^(M-1)-1: o_ovf<=1 and o_val <= +(2^(M-1)-1), or -(2^(M-1)-1) when negative. Saturation is symmetric.
  - Else: o_val <= negative ? -mag : mag. Negative zero yields 0.
  - done<=1, then go to IDLE.
- Latency, counted from the edge that samples i_ce to the edge where done rises:
  - integer: 9 cycles;
  - fixed: 9+I_FRAC cycles (17 at default).
- i_ce held high continuously starts a new conversion in the cycle after done.

Optional Feature:
BCD_FRAC_ROUND_EN:
- Defined:
  - FRAC runs I_FRAC+1 cycles. The extra carry is a round bit; the fraction is rounded half-up with carry into the integer part before the overflow check.
  - Fixed latency is 18 cycles.
- Undefined: the fraction is truncated after I_FRAC bits.

Decomposition:
- define.v holds:
  - state encodings (IDLE, LOAD, INT, FRAC, FINISH);
  - BCD_SIGN_POS=4'h0 and BCD_SIGN_NEG=4'hF, shared with the display path;
  - integer and fraction digit counts (7 each).
- One sub-module, bcd_frac_double:
  - combinational, one doubling step on a 28-bit BCD fraction;
  - outputs the next fraction and the carry bit.

Test Plan (M=32, I_FRAC=8):
- Integer: sign 0, integer digits 0000123, i_fixed=0 -> o_val=0x0000007B, o_err=0, o_ovf=0, done exactly 9 cycles after the i_ce edge, busy high throughout.
- Negative fixed: sign F, integer 0000003, fraction 5000000, i_fixed=1 -> o_val=0xFFFFFC80 (-3.5), done at 17 cycles.
- Fraction 0.1 (integer 0, fraction 1000000, i_fixed=1):
  - o_val=0x00000019 without the macro;
  - o_val=0x0000001A with BCD_FRAC_ROUND_EN, done at 18 cycles.
- Overflow: integer 9999999, i_fixed=1 -> o_ovf=1, o_val=0x7FFFFFFF. The same with sign F -> o_val=0x80000001.
- Error cases, each -> o_err=1, o_val=0:
  - integer digit 4'hA;
  - sign nibble 4'h5;
  - i_fixed=0 with a garbage fraction 0xFFFFFFF -> no error, conversion proceeds normally.
- Robustness:
  - i_ce pulses during busy -> ignored, one done only.
  - RST_N low in cycle 5 of INT -> all outputs 0 immediately, no done pulse.
  - A fresh i_ce after reset release converts correctly.
